// File: rtl/mem_controller_if.sv
// mem_controller_if: CPU-side and backing-memory-side bus bundle for mem_controller.
//   slave  : controller view (CPU requests + ext responses in, results + ext requests out)
//   master : environment view (CPU and backing memory)
interface mem_controller_if;
  logic [31:0] mem_instr_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] mem_instr_data;
  logic [31:0] mem_rd_data;
  logic        mem_valid;
  logic        mem_err;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_we;
  logic        ext_req;
  logic [31:0] ext_rdata;
  logic        ext_ack;
  modport slave (
    input  mem_instr_addr, mem_addr, mem_wr_data, mem_wr, mem_rd, ext_rdata, ext_ack,
    output mem_instr_data, mem_rd_data, mem_valid, mem_err, ext_addr, ext_wdata, ext_we, ext_req
  );
  modport master (
    output mem_instr_addr, mem_addr, mem_wr_data, mem_wr, mem_rd, ext_rdata, ext_ack,
    input  mem_instr_data, mem_rd_data, mem_valid, mem_err, ext_addr, ext_wdata, ext_we, ext_req
  );
endinterface

// File: rtl/mem_controller.sv
// mem_controller: sequences an optional data access then an instruction fetch onto one backing memory.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_controller_if.slave (CPU request/result and backing-memory request/response)
//   TIMEOUT  : max cycles to wait for ext_ack per access (1-255)
//   ERR_DATA : read data substituted on a timed-out read or fetch
module mem_controller #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input logic             clk,
  input logic             rst_n,
  mem_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [31:0] ext_addr_q, ext_addr_d, ext_wdata_q, ext_wdata_d;
  logic        ext_we_q, ext_we_d, ext_req_q, ext_req_d;
  logic [31:0] instr_q, instr_d, rd_data_q, rd_data_d;
  logic        valid_q, valid_d, err_q, err_d, mem_err_q, mem_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy, tmo, fin;
  logic [31:0] reply;
  assign busy  = state_q == DATA || state_q == FETCH;
  // The final waiting cycle times out only if ext_ack is absent; an ack there still wins.
  assign tmo   = busy && !bus.ext_ack && cnt_q == LAST;
  assign fin   = busy && (bus.ext_ack || tmo);
  assign reply = bus.ext_ack ? bus.ext_rdata : ERR_DATA;
  always_comb begin
    state_d     = state_q;
    iaddr_d     = iaddr_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_we_d    = ext_we_q;
    instr_d     = instr_q;
    rd_data_d   = rd_data_q;
    err_d       = err_q;
    cnt_d       = fin ? 8'd0 : cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        iaddr_d     = bus.mem_instr_addr;
        wr_d        = bus.mem_wr;
        rd_d        = bus.mem_rd;
        err_d       = 1'b0;
        cnt_d       = 8'd0;
        state_d     = (bus.mem_wr || bus.mem_rd) ? DATA : FETCH;
        ext_addr_d  = (bus.mem_wr || bus.mem_rd) ? bus.mem_addr : bus.mem_instr_addr;
        ext_we_d    = bus.mem_wr;
        ext_wdata_d = bus.mem_wr_data;
      end
      DATA: if (fin) begin
        state_d    = FETCH;
        ext_addr_d = iaddr_q;
        ext_we_d   = 1'b0;
        err_d      = err_q | tmo;
        // Write wins when both requests were captured, so only a pure read updates load data.
        rd_data_d  = (rd_q && !wr_q) ? reply : rd_data_q;
      end
      FETCH: if (fin) begin
        state_d = DONE;
        instr_d = reply;
        err_d   = err_q | tmo;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered decodes of the next state so they align with the state register.
    ext_req_d = state_d == DATA || state_d == FETCH;
    valid_d   = state_d == DONE;
    mem_err_d = valid_d && err_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iaddr_q     <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_we_q    <= 1'b0;
      ext_req_q   <= 1'b0;
      instr_q     <= '0;
      rd_data_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      iaddr_q     <= iaddr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_we_q    <= ext_we_d;
      ext_req_q   <= ext_req_d;
      instr_q     <= instr_d;
      rd_data_q   <= rd_data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      mem_err_q   <= mem_err_d;
      cnt_q       <= cnt_d;
    end
  end
  assign bus.ext_addr       = ext_addr_q;
  assign bus.ext_wdata      = ext_wdata_q;
  assign bus.ext_we         = ext_we_q;
  assign bus.ext_req        = ext_req_q;
  assign bus.mem_instr_data = instr_q;
  assign bus.mem_rd_data    = rd_data_q;
  assign bus.mem_valid      = valid_q;
  assign bus.mem_err        = mem_err_q;
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: scoreboard bench for mem_controller with a scripted backing-memory responder.
module tb_mem_controller;
  localparam int          T     = 4;
  localparam int          NEVER = 255;
  localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] reply;
  } seg_t;
  typedef struct {
    logic [31:0] rd;
    logic [31:0] instr;
    logic        err;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_controller_if bus();
  mem_controller #(.TIMEOUT(T), .ERR_DATA(ERR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  seg_t        seg_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_instr = '0;
  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask
  // Backing memory: serves the expected access sequence in order, acking after a scripted delay.
  // Outside a request it drives a spurious ack that the controller must ignore.
  initial begin
    int wait_n = 0;
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.ext_req) begin
        wait_n        = 0;
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = 32'h0BAD_0BAD;
      end else if (seg_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_req addr=%h we=%b", bus.ext_addr, bus.ext_we);
        bus.ext_ack = 1'b1;
      end else begin
        checks++;
        if (bus.ext_addr !== seg_q[0].addr || bus.ext_we !== seg_q[0].we ||
            (seg_q[0].we && bus.ext_wdata !== seg_q[0].wdata)) begin
          failures++;
          $display("FAIL ext_access got addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h",
                   bus.ext_addr, bus.ext_we, bus.ext_wdata, seg_q[0].addr, seg_q[0].we, seg_q[0].wdata);
        end
        bus.ext_ack   = wait_n == seg_q[0].delay;
        bus.ext_rdata = bus.ext_ack ? seg_q[0].reply : 32'h5555_5555;
        if (bus.ext_ack || wait_n == T - 1) begin
          void'(seg_q.pop_front());
          wait_n = 0;
        end else wait_n++;
      end
    end
  end
  // Starts at a negedge just before the IDLE cycle (DONE cycle, or during reset when rel=1).
  task automatic run_txn(input string name, input logic rel, input logic [31:0] ia, da, wd,
                         input logic wr, rd, input int dd, input logic [31:0] dr,
                         input int fd, input logic [31:0] fr, input logic scramble);
    exp_t e;
    int lat, dc, fc;
    bus.mem_instr_addr = ia;
    bus.mem_addr       = da;
    bus.mem_wr_data    = wd;
    bus.mem_wr         = wr;
    bus.mem_rd         = rd;
    if (wr || rd) seg_q.push_back('{da, wr, wd, dd, dr});
    seg_q.push_back('{ia, 1'b0, 32'h0, fd, fr});
    if (rd && !wr) m_rd = dd < T ? dr : ERR;
    m_instr = fd < T ? fr : ERR;
    dc = (wr || rd) ? (dd < T ? dd + 1 : T) : 0;
    fc = fd < T ? fd + 1 : T;
    e = '{m_rd, m_instr, ((wr || rd) && dd >= T) || fd >= T, (rel ? 1 : 2) + dc + fc};
    exp_q.push_back(e);
    if (rel) rst_n = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (scramble && lat == (rel ? 1 : 2)) begin
        bus.mem_instr_addr = ~ia;
        bus.mem_addr       = ~da;
        bus.mem_wr_data    = ~wd;
        bus.mem_wr         = ~wr;
        bus.mem_rd         = ~rd;
      end
      if (bus.mem_err && !bus.mem_valid) begin
        checks++;
        failures++;
        $display("FAIL %s stray_err got=1 exp=0", name);
      end
    end while (!bus.mem_valid && lat < 40);
    checks++;
    if (!bus.mem_valid) begin
      failures++;
      $display("FAIL %s valid_timeout got=0 exp=1", name);
      summary_and_finish();
    end
    e = exp_q.pop_front();
    checks += 5;
    if (lat !== e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, e.lat); end
    if (bus.mem_rd_data !== e.rd) begin failures++; $display("FAIL %s rd_data got=%h exp=%h", name, bus.mem_rd_data, e.rd); end
    if (bus.mem_instr_data !== e.instr) begin failures++; $display("FAIL %s instr_data got=%h exp=%h", name, bus.mem_instr_data, e.instr); end
    if (bus.mem_err !== e.err) begin failures++; $display("FAIL %s mem_err got=%b exp=%b", name, bus.mem_err, e.err); end
    if (seg_q.size() != 0) begin failures++; $display("FAIL %s pending_access got=%0d exp=0", name, seg_q.size()); end
  endtask
  task automatic test_reset();
    bus.mem_instr_addr = '0;
    bus.mem_addr       = '0;
    bus.mem_wr_data    = '0;
    bus.mem_wr         = 1'b0;
    bus.mem_rd         = 1'b0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (bus.ext_req !== 1'b0) begin failures++; $display("FAIL reset ext_req got=%b exp=0", bus.ext_req); end
    if ({bus.ext_we, bus.ext_addr, bus.ext_wdata, bus.mem_valid, bus.mem_err, bus.mem_instr_data, bus.mem_rd_data} !== '0) begin
      failures++;
      $display("FAIL reset outputs got we=%b addr=%h wdata=%h valid=%b err=%b instr=%h rd=%h exp all 0",
               bus.ext_we, bus.ext_addr, bus.ext_wdata, bus.mem_valid, bus.mem_err, bus.mem_instr_data, bus.mem_rd_data);
    end
  endtask
  task automatic test_fetch_only();
    run_txn("fetch_only", 1'b1, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 0, 32'h1234_5678, 1'b0);
  endtask
  task automatic test_load_fetch();
    run_txn("load_fetch", 1'b0, 32'h104, 32'h2000, 32'h0, 1'b0, 1'b1, 0, 32'hAAAA_0001, 0, 32'hBBBB_0002, 1'b0);
  endtask
  task automatic test_store();
    run_txn("store_slow", 1'b0, 32'h108, 32'h40, 32'hCAFE_F00D, 1'b1, 1'b0, 3, 32'h0, 0, 32'h1111_2222, 1'b0);
    run_txn("wr_and_rd", 1'b0, 32'h10C, 32'h44, 32'h0123_4567, 1'b1, 1'b1, 1, 32'h7777_7777, 2, 32'h3333_4444, 1'b0);
  endtask
  task automatic test_timeout();
    run_txn("rd_timeout", 1'b0, 32'h110, 32'h80, 32'h0, 1'b0, 1'b1, NEVER, 32'h0, 0, 32'h5151_5151, 1'b0);
    run_txn("after_tmo", 1'b0, 32'h114, 32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1, 32'h6262_6262, 1'b0);
    run_txn("fetch_tmo", 1'b0, 32'h118, 32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0, NEVER, 32'h0, 1'b0);
    run_txn("wr_tmo", 1'b0, 32'h11C, 32'h84, 32'h9999_0000, 1'b1, 1'b0, NEVER, 32'h0, 3, 32'h7373_7373, 1'b0);
  endtask
  task automatic test_capture();
    run_txn("capture", 1'b0, 32'h120, 32'h3000, 32'h0, 1'b0, 1'b1, 2, 32'hA5A5_5A5A, 1, 32'hC3C3_3C3C, 1'b1);
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      logic [1:0] k;
      k = 2'($urandom_range(0, 3));
      run_txn("b2b", 1'b0, $urandom, $urandom, $urandom, k[0], k[1],
              $urandom_range(0, T), $urandom, $urandom_range(0, T), $urandom, 1'(i % 3 == 0));
    end
  endtask
  task automatic test_reset_mid_data();
    bus.mem_instr_addr = 32'h200;
    bus.mem_addr       = 32'h3000;
    bus.mem_rd         = 1'b1;
    bus.mem_wr         = 1'b0;
    seg_q.push_back('{32'h3000, 1'b0, 32'h0, NEVER, 32'h0});
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ext_req !== 1'b1) begin failures++; $display("FAIL mid_reset req_before got=%b exp=1", bus.ext_req); end
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (bus.ext_req !== 1'b0) begin failures++; $display("FAIL mid_reset ext_req got=%b exp=0", bus.ext_req); end
    if ({bus.ext_we, bus.ext_addr, bus.ext_wdata, bus.mem_valid, bus.mem_err, bus.mem_instr_data, bus.mem_rd_data} !== '0) begin
      failures++;
      $display("FAIL mid_reset outputs got addr=%h instr=%h rd=%h valid=%b exp all 0",
               bus.ext_addr, bus.mem_instr_data, bus.mem_rd_data, bus.mem_valid);
    end
    seg_q.delete();
    m_rd    = '0;
    m_instr = '0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.mem_valid !== 1'b0 || bus.ext_req !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset held got valid=%b req=%b exp 0 0", bus.mem_valid, bus.ext_req);
      end
    end
    run_txn("post_reset", 1'b1, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1, 32'hFEED_0001, 1'b0);
  endtask
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_fetch_only();
    test_load_fetch();
    test_store();
    test_timeout();
    test_capture();
    test_back_to_back();
    test_reset_mid_data();
    summary_and_finish();
  end
endmodule
